// File: rtl/subterranean_lwc_dout_packer_if.sv
// -----------------------------------------------------------------------------
// subterranean_lwc_dout_packer_if
// Bus bundle between the Subterranean core output chunk stream and the
// output buffer word stream.
//   din/din_size/din_last/din_valid : chunk stream into the packer
//   din_ready                       : packer can accept a chunk
//   dout/dout_last/dout_valid       : packed word stream out of the packer
//   dout_ready                      : output buffer can accept a word
// Modports: master = environment side (drives chunks, sinks words),
//           slave  = packer side.
// -----------------------------------------------------------------------------
interface subterranean_lwc_dout_packer_if #(
   parameter int G_WIDTH  = 32,
   parameter int G_SIZE_W = 3
);
   logic [G_WIDTH-1:0]  din;
   logic [G_SIZE_W-1:0] din_size;
   logic                din_last;
   logic                din_valid;
   logic                din_ready;
   logic [G_WIDTH-1:0]  dout;
   logic                dout_last;
   logic                dout_valid;
   logic                dout_ready;

   modport master (
      output din, din_size, din_last, din_valid,
      input  din_ready,
      input  dout, dout_last, dout_valid,
      output dout_ready
   );

   modport slave (
      input  din, din_size, din_last, din_valid,
      output din_ready,
      output dout, dout_last, dout_valid,
      input  dout_ready
   );
endinterface

// File: rtl/subterranean_lwc_dout_packer.sv
// -----------------------------------------------------------------------------
// subterranean_lwc_dout_packer
// Byte-granular packer: collects left-aligned chunks of 0..B valid bytes and
// emits full G_WIDTH words MSB-first; the final partial word is zero-filled
// and flagged last.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   packer_clear : synchronous clear, discards all state
//   bus          : slave side of subterranean_lwc_dout_packer_if
// Optional build macro SUBTERRANEAN_LWC_PACKER_PAD_EN: a 0x01 pad byte is
// placed right after the final data byte, which yields an extra 0x01 00..00
// word when the data ends on a word boundary.
// -----------------------------------------------------------------------------
module subterranean_lwc_dout_packer #(
   parameter int G_WIDTH  = 32,
   parameter int G_SIZE_W = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          packer_clear,
   subterranean_lwc_dout_packer_if.slave bus
);
   localparam int B  = G_WIDTH / 8;
`ifdef SUBTERRANEAN_LWC_PACKER_PAD_EN
   // one extra byte so a full chunk plus its pad byte always fits
   localparam int NB = 2 * B + 1;
`else
   localparam int NB = 2 * B;
`endif
   localparam int NW = NB * 8;
   localparam int CW = $clog2(NB + 1);

   localparam logic [CW-1:0] B_C      = CW'(B);
   localparam logic [0:0]    ST_ACCUM = 1'b0;
   localparam logic [0:0]    ST_FLUSH = 1'b1;

   // byte 0 of the buffer sits at the MSB; bytes at index >= fcnt are always 0
   logic [NW-1:0] sbuf_q, sbuf_d;
   logic [CW-1:0] fcnt_q, fcnt_d;
   logic [0:0]    state_q, state_d;
   logic          run_q;

   logic          in_fire_s;
   logic          out_fire_s;
   logic          din_ready_s;
   logic          dout_valid_s;
   logic          dout_last_s;
   logic [CW-1:0] size_s;
   logic [CW-1:0] out_bytes_s;
   logic [CW-1:0] fcnt_sh_s;
   logic [NW-1:0] sbuf_sh_s;
   logic [G_WIDTH-1:0] din_mask_s;
   logic [NW-1:0] din_ext_s;
`ifdef SUBTERRANEAN_LWC_PACKER_PAD_EN
   logic [CW-1:0] pad_pos_s;
   logic [NW-1:0] pad_ext_s;
`endif

   // handshake flags derived from registers only (no din_valid -> din_ready path)
   always_comb begin
      din_ready_s  = run_q && (state_q == ST_ACCUM) && (fcnt_q <= B_C);
      dout_valid_s = (fcnt_q >= B_C) || (state_q == ST_FLUSH);
      dout_last_s  = (state_q == ST_FLUSH) && (fcnt_q <= B_C);
      in_fire_s    = bus.din_valid && din_ready_s;
      out_fire_s   = dout_valid_s && bus.dout_ready;
   end

   // clamp an illegal oversize chunk to a full word
   always_comb begin
      if (bus.din_size > G_SIZE_W'(B)) begin
         size_s = B_C;
      end else begin
         size_s = CW'(bus.din_size);
      end
   end

   // next buffer/fill: shift out the presented word first, then append the chunk
   always_comb begin
      if (!out_fire_s) begin
         out_bytes_s = {CW{1'b0}};
      end else if (fcnt_q >= B_C) begin
         out_bytes_s = B_C;
      end else begin
         out_bytes_s = fcnt_q;
      end
      fcnt_sh_s  = fcnt_q - out_bytes_s;
      sbuf_sh_s  = sbuf_q << {out_bytes_s, 3'b000};
      // drop bytes beyond din_size so the zero-tail invariant holds
      din_mask_s = ~({G_WIDTH{1'b1}} >> {size_s, 3'b000});
      din_ext_s  = {(bus.din & din_mask_s), {(NW - G_WIDTH){1'b0}}} >> {fcnt_sh_s, 3'b000};
`ifdef SUBTERRANEAN_LWC_PACKER_PAD_EN
      pad_pos_s  = fcnt_sh_s + size_s;
      pad_ext_s  = {8'h01, {(NW - 8){1'b0}}} >> {pad_pos_s, 3'b000};
`endif
      sbuf_d = sbuf_sh_s;
      fcnt_d = fcnt_sh_s;
      if (in_fire_s) begin
`ifdef SUBTERRANEAN_LWC_PACKER_PAD_EN
         if (bus.din_last) begin
            sbuf_d = sbuf_sh_s | din_ext_s | pad_ext_s;
            fcnt_d = pad_pos_s + {{(CW-1){1'b0}}, 1'b1};
         end else begin
            sbuf_d = sbuf_sh_s | din_ext_s;
            fcnt_d = fcnt_sh_s + size_s;
         end
`else
         sbuf_d = sbuf_sh_s | din_ext_s;
         fcnt_d = fcnt_sh_s + size_s;
`endif
      end else begin
         sbuf_d = sbuf_sh_s;
         fcnt_d = fcnt_sh_s;
      end
   end

   // message state: last chunk enters FLUSH, handshake of the last word returns
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACCUM: begin
            if (in_fire_s && bus.din_last) begin
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_FLUSH: begin
            if (out_fire_s && dout_last_s) begin
               state_d = ST_ACCUM;
            end else begin
               state_d = ST_FLUSH;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   // state registers with async reset and synchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sbuf_q  <= {NW{1'b0}};
         fcnt_q  <= {CW{1'b0}};
         state_q <= ST_ACCUM;
      end else if (packer_clear) begin
         sbuf_q  <= {NW{1'b0}};
         fcnt_q  <= {CW{1'b0}};
         state_q <= ST_ACCUM;
      end else begin
         sbuf_q  <= sbuf_d;
         fcnt_q  <= fcnt_d;
         state_q <= state_d;
      end
   end

   // holds din_ready low while reset is asserted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
      end
   end

   assign bus.din_ready  = din_ready_s;
   assign bus.dout_valid = dout_valid_s;
   assign bus.dout_last  = dout_last_s;
   assign bus.dout       = sbuf_q[NW-1 -: G_WIDTH];

endmodule

// File: tb/tb_subterranean_lwc_dout_packer.sv
module tb_subterranean_lwc_dout_packer;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n;
   logic packer_clear;

   always #5 clk = ~clk;

   subterranean_lwc_dout_packer_if #(.G_WIDTH(W), .G_SIZE_W(3)) bus ();

   subterranean_lwc_dout_packer #(.G_WIDTH(W), .G_SIZE_W(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .packer_clear (packer_clear),
      .bus          (bus)
   );

   int         tests_run    = 0;
   int         tests_failed = 0;
   logic [W:0] exp_q[$];        // {last, word}
   logic       in_acc   = 1'b0;
   logic       out_fire = 1'b0;
   logic       held_v   = 1'b0;
   logic [W:0] held     = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] w, input logic last);
      exp_q.push_back({last, w});
   endtask

   // negedge sampling: stall stability and scoreboard pop on an output handshake
   task automatic sample();
      logic [W:0] e;
      in_acc   = bus.din_valid & bus.din_ready;
      out_fire = bus.dout_valid & bus.dout_ready;
      if (held_v) begin
         chk("stall_valid", 64'(bus.dout_valid), 64'd1);
         chk("stall_stable", 64'({bus.dout_last, bus.dout}), 64'(held));
      end
      if (out_fire) begin
         tests_run++;
         assert (exp_q.size() > 0) else begin
            tests_failed++;
            $error("FAIL spurious_word: observed %0h expected no word", {bus.dout_last, bus.dout});
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dout_word", 64'({bus.dout_last, bus.dout}), 64'(e));
         end
      end
      held_v = bus.dout_valid & ~bus.dout_ready & rst_n & ~packer_clear;
      held   = {bus.dout_last, bus.dout};
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d, input logic [2:0] sz, input logic last);
      int n;
      n = 0;
      bus.din = d; bus.din_size = sz; bus.din_last = last; bus.din_valid = 1'b1;
      do begin
         tick();
         n++;
      end while (!in_acc && n < 40);
      chk("send_accept", 64'(in_acc), 64'd1);
      bus.din_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 60) begin
         tick();
         n++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      rst_n = 1'b1; packer_clear = 1'b0;
      bus.din = '0; bus.din_size = 3'd0; bus.din_last = 1'b0; bus.din_valid = 1'b0;
      bus.dout_ready = 1'b0;
      #2 rst_n = 1'b0;
      #2;
      // reset state
      chk("rst_din_ready", 64'(bus.din_ready), 64'd0);
      chk("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
      chk("rst_dout", 64'(bus.dout), 64'd0);
      chk("rst_dout_last", 64'(bus.dout_last), 64'd0);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("post_rst_din_ready", 64'(bus.din_ready), 64'd1);
      chk("post_rst_dout_valid", 64'(bus.dout_valid), 64'd0);

      // byte stream 0x11..0x77, junk in unused low bytes
      bus.dout_ready = 1'b1;
      push(32'h11223344, 1'b0);
`ifdef SUBTERRANEAN_LWC_PACKER_PAD_EN
      push(32'h55667701, 1'b1);
`else
      push(32'h55667700, 1'b1);
`endif
      for (int i = 1; i <= 7; i++) begin
         send({8'(i * 17), 24'hA5A5A5}, 3'd1, (i == 7));
      end
      drain();
      chk("bytes_back_accum", 64'(bus.din_ready), 64'd1);

      // straddle across word boundary
      push(32'hAABBCCDD, 1'b0);
`ifdef SUBTERRANEAN_LWC_PACKER_PAD_EN
      push(32'hEEFF0100, 1'b1);
`else
      push(32'hEEFF0000, 1'b1);
`endif
      send(32'hAABBCC77, 3'd3, 1'b0);
      send(32'hDDEEFF99, 3'd3, 1'b1);
      drain();

      // backpressure
      bus.dout_ready = 1'b0;
      push(32'h01020304, 1'b0);
      push(32'h05060708, 1'b0);
`ifdef SUBTERRANEAN_LWC_PACKER_PAD_EN
      push(32'h090A0B0C, 1'b0);
      push(32'h01000000, 1'b1);
`else
      push(32'h090A0B0C, 1'b1);
`endif
      send(32'h01020304, 3'd4, 1'b0);
      send(32'h05060708, 3'd4, 1'b0);
      chk("bp_din_ready_low", 64'(bus.din_ready), 64'd0);
      chk("bp_dout_valid", 64'(bus.dout_valid), 64'd1);
      chk("bp_dout_head", 64'(bus.dout), 64'h01020304);
      bus.din = 32'h090A0B0C; bus.din_size = 3'd4; bus.din_last = 1'b1; bus.din_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_stall_din_ready", 64'(bus.din_ready), 64'd0);
      end
      bus.dout_ready = 1'b1;
      send(32'h090A0B0C, 3'd4, 1'b1);
      drain();

      // zero-length message with junk data
`ifdef SUBTERRANEAN_LWC_PACKER_PAD_EN
      push(32'h01000000, 1'b1);
`else
      push(32'h00000000, 1'b1);
`endif
      send(32'hDEADBEEF, 3'd0, 1'b1);
      drain();

      // oversize din_size is treated as a full word
      push(32'hCAFEF00D, 1'b0);
      push(32'h12345678, 1'b0);
      send(32'hCAFEF00D, 3'd7, 1'b0);
      send(32'h12345678, 3'd4, 1'b0);
      drain();

      // 16 back-to-back full chunks, one word per cycle
      for (int i = 0; i < 16; i++) begin
         push({8'(i), 8'hC3, ~8'(i), 8'h5A}, 1'b0);
      end
      for (int i = 0; i < 16; i++) begin
         bus.din = {8'(i), 8'hC3, ~8'(i), 8'h5A}; bus.din_size = 3'd4;
         bus.din_last = 1'b0; bus.din_valid = 1'b1;
         tick();
         chk("stream_accept", 64'(in_acc), 64'd1);
         if (i > 0) chk("stream_out_fire", 64'(out_fire), 64'd1);
      end
      bus.din_valid = 1'b0;
      tick();
      chk("stream_last_fire", 64'(out_fire), 64'd1);
      chk("stream_q_empty", 64'(exp_q.size()), 64'd0);

      // clear with two pending bytes
      send(32'hBEEF1234, 3'd2, 1'b0);
      chk("clr_pre_valid", 64'(bus.dout_valid), 64'd0);
      packer_clear = 1'b1;
      tick();
      packer_clear = 1'b0;
      chk("clr_dout_valid", 64'(bus.dout_valid), 64'd0);
      chk("clr_din_ready", 64'(bus.din_ready), 64'd1);
      chk("clr_dout", 64'(bus.dout), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("clr_quiet", 64'({bus.dout_valid, bus.dout_last}), 64'd0);
      end
`ifdef SUBTERRANEAN_LWC_PACKER_PAD_EN
      push(32'h12345678, 1'b0);
      push(32'h01000000, 1'b1);
`else
      push(32'h12345678, 1'b1);
`endif
      send(32'h12345678, 3'd4, 1'b1);
      drain();

      // async reset mid-message with fcnt=3
      send(32'h99887766, 3'd3, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_din_ready", 64'(bus.din_ready), 64'd0);
      chk("mid_rst_dout_valid", 64'(bus.dout_valid), 64'd0);
      chk("mid_rst_dout", 64'({bus.dout_last, bus.dout}), 64'd0);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("mid_rst_rel_din_ready", 64'(bus.din_ready), 64'd1);
      chk("mid_rst_rel_dout_valid", 64'(bus.dout_valid), 64'd0);
`ifdef SUBTERRANEAN_LWC_PACKER_PAD_EN
      push(32'hABCD0100, 1'b1);
`else
      push(32'hABCD0000, 1'b1);
`endif
      send(32'hABCDEF12, 3'd2, 1'b1);
      drain();
      tick();
      chk("end_idle_valid", 64'(bus.dout_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
